// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind a req/ready handshake.
// Serves byte, half and word loads/stores for the core datapath. Loads are
// returned right-justified and zero-filled. Misaligned, out-of-range and
// illegal-size accesses complete with o_err and leave the RAM untouched.
// Outputs are registered: o_ready/o_err/o_readData are driven for the cycle
// that follows the RESP state, and that same cycle (back in IDLE) may already
// accept the next request.
module dmem_responder #(
   parameter int          DEPTH_LOG2 = 10,
   parameter int          LATENCY    = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset_x,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [1:0]  i_memSize,
   input  logic [31:0] i_writeData,
   output logic        o_ready,
   output logic [31:0] o_readData,
   output logic        o_err,
   output logic        o_busy
);

   localparam int          DEPTH = 1 << DEPTH_LOG2;
   localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                state;
   logic [3:0]            wait_cnt;

   logic                  lat_we;
   logic                  lat_err;
   logic [1:0]            lat_size;
   logic [1:0]            lat_off;
   logic [DEPTH_LOG2-1:0] lat_index;
   logic [31:0]           lat_wdata;

   logic [31:0]           mem [DEPTH];

   logic [31:0]           req_offset;
   logic                  in_range;
   logic                  misaligned;
   logic                  req_fault;

   logic [31:0]           cur_word;
   logic [31:0]           load_data;
   logic [31:0]           store_data;
   logic [3:0]            byte_en;

   // Classify the incoming request; the offset compare avoids overflow of BASE+SPAN
   always_comb begin
      req_offset = i_addr - BASE_ADDR;
      in_range   = (i_addr >= BASE_ADDR) && (req_offset < SPAN);
      case (i_memSize)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = i_addr[0];
         2'b10:   misaligned = |i_addr[1:0];
         default: misaligned = 1'b1;
      endcase
      req_fault = misaligned || !in_range;
   end

   // Steer lanes of the latched access: byte enables and replicated store data, extracted load data
   always_comb begin
      cur_word   = mem[lat_index];
      store_data = lat_wdata;
      byte_en    = 4'b0000;
      load_data  = 32'h0000_0000;
      case (lat_size)
         2'b00: begin
            byte_en    = 4'b0001 << lat_off;
            store_data = {4{lat_wdata[7:0]}};
            load_data  = {24'h00_0000, cur_word[{lat_off, 3'b000} +: 8]};
         end
         2'b01: begin
            byte_en    = lat_off[1] ? 4'b1100 : 4'b0011;
            store_data = {2{lat_wdata[15:0]}};
            load_data  = {16'h0000, cur_word[{lat_off[1], 4'b0000} +: 16]};
         end
         2'b10: begin
            byte_en    = 4'b1111;
            store_data = lat_wdata;
            load_data  = cur_word;
         end
         default: begin
            byte_en    = 4'b0000;
         end
      endcase
   end

   // Handshake FSM: latch the request, count out the latency, then pulse the registered response
   always_ff @(posedge i_clk) begin
      if (i_reset_x) begin
         state      <= S_IDLE;
         wait_cnt   <= 4'd0;
         o_ready    <= 1'b0;
         o_readData <= 32'h0000_0000;
         o_err      <= 1'b0;
         o_busy     <= 1'b0;
         lat_we     <= 1'b0;
         lat_err    <= 1'b0;
         lat_size   <= 2'b00;
         lat_off    <= 2'b00;
         lat_index  <= '0;
         lat_wdata  <= 32'h0000_0000;
      end else begin
         o_ready    <= 1'b0;
         o_readData <= 32'h0000_0000;
         o_err      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_req) begin
                  lat_we    <= i_we;
                  lat_err   <= req_fault;
                  lat_size  <= i_memSize;
                  lat_off   <= i_addr[1:0];
                  lat_index <= req_offset[DEPTH_LOG2+1:2];
                  lat_wdata <= i_writeData;
                  o_busy    <= 1'b1;
                  state     <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               if (LATENCY == 0) begin
                  state <= S_RESP;
               end else begin
                  wait_cnt <= 4'(LATENCY - 1);
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_RESP: begin
               o_ready    <= 1'b1;
               o_err      <= lat_err;
               o_readData <= (lat_we || lat_err) ? 32'h0000_0000 : load_data;
               o_busy     <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Commit a fault-free store on the edge leaving RESP; reset on that edge drops it
   always_ff @(posedge i_clk) begin
      if (!i_reset_x && (state == S_RESP) && lat_we && !lat_err) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[lat_index][8*i +: 8] <= store_data[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// Two instances: a LATENCY=2 responder at base 0 (4 KiB) and a LATENCY=0
// responder at base 0x1000 (64 words). A byte-addressed array models the RAM.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;

   logic        req, we, ready, err, busy;
   logic [31:0] addr, wdata, rdata;
   logic [1:0]  size;

   logic        req0, we0, ready0, err0, busy0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [1:0]  size0;

   int          tests_run    = 0;
   int          tests_failed = 0;

   logic [7:0]  mbytes [0:4095];

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_LOG2(10),
      .LATENCY   (2),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .i_clk      (clk),
      .i_reset_x  (reset),
      .i_req      (req),
      .i_we       (we),
      .i_addr     (addr),
      .i_memSize  (size),
      .i_writeData(wdata),
      .o_ready    (ready),
      .o_readData (rdata),
      .o_err      (err),
      .o_busy     (busy)
   );

   dmem_responder #(
      .DEPTH_LOG2(6),
      .LATENCY   (0),
      .BASE_ADDR (32'h0000_1000)
   ) dut0 (
      .i_clk      (clk),
      .i_reset_x  (reset),
      .i_req      (req0),
      .i_we       (we0),
      .i_addr     (addr0),
      .i_memSize  (size0),
      .i_writeData(wdata0),
      .o_ready    (ready0),
      .o_readData (rdata0),
      .o_err      (err0),
      .o_busy     (busy0)
   );

   // Reference model: byte-addressed memory and the fault rules in plain arithmetic
   function automatic bit model_fault(input logic [31:0] a, input logic [1:0] s,
                                      input longint base, input longint span);
      longint ua;
      ua = longint'(a);
      if (s == 2'b11) return 1'b1;
      if (ua < base || ua >= base + span) return 1'b1;
      if (s == 2'b01 && (a % 2) != 0) return 1'b1;
      if (s == 2'b10 && (a % 4) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < (1 << s); i++) begin
         v = v | (32'(mbytes[int'(a) + i]) << (8 * i));
      end
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      for (int i = 0; i < (1 << s); i++) begin
         mbytes[int'(a) + i] = d[8*i +: 8];
      end
   endtask

   // One complete access; lat counts edges after the sampling edge until o_ready (-1 on timeout)
   task automatic access(input bit sel, input bit w, input logic [31:0] a, input logic [1:0] s,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e,
                         output int lat);
      @(negedge clk);
      if (sel) begin
         req0 = 1'b1; we0 = w; addr0 = a; size0 = s; wdata0 = wd;
      end else begin
         req = 1'b1; we = w; addr = a; size = s; wdata = wd;
      end
      @(posedge clk);
      #1;
      lat = -1;
      rd  = 'x;
      e   = 1'bx;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (sel ? ready0 : ready) begin
            lat = i;
            rd  = sel ? rdata0 : rdata;
            e   = sel ? err0 : err;
            break;
         end
      end
      req  = 1'b0;
      req0 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if ({ready, err, busy, rdata, ready0, err0, busy0, rdata0} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got ready=%b err=%b busy=%b data=%h / ready0=%b err0=%b busy0=%b data0=%h, expected all zero",
                     ready, err, busy, rdata, ready0, err0, busy0, rdata0);
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset_abort();
      logic [31:0] d;
      logic        e;
      int          lat;
      bit          seen;
      access(0, 1'b1, 32'h10, 2'b10, 32'h1122_3344, d, e, lat);
      model_store(32'h10, 2'b10, 32'h1122_3344);
      tests_run++;
      if (e !== 1'b0 || lat != 4) begin
         tests_failed++;
         $display("[TB] FAIL abort_prestore: got err=%b lat=%0d, expected err=0 lat=4", e, lat);
      end
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h10; size = 2'b10; wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      req   = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if ({ready, err, busy, rdata} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL abort_reset_outputs: got ready=%b err=%b busy=%b data=%h, expected all zero",
                     ready, err, busy, rdata);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (ready !== 1'b0) seen = 1'b1;
      end
      tests_run++;
      if (seen) begin
         tests_failed++;
         $display("[TB] FAIL abort_no_ready: got o_ready pulse after aborted store, expected none");
      end
      access(0, 1'b0, 32'h10, 2'b10, 32'h0, d, e, lat);
      tests_run++;
      if (d !== 32'h1122_3344 || e !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL abort_reload: got data=%h err=%b, expected data=11223344 err=0", d, e);
      end
   endtask

   task automatic test_word();
      logic [31:0] d;
      logic        e;
      int          lat;
      access(0, 1'b1, 32'h20, 2'b10, 32'h1234_5678, d, e, lat);
      model_store(32'h20, 2'b10, 32'h1234_5678);
      tests_run++;
      if (e !== 1'b0 || d !== 32'h0 || lat != 4) begin
         tests_failed++;
         $display("[TB] FAIL word_store: got err=%b data=%h lat=%0d, expected err=0 data=0 lat=4", e, d, lat);
      end
      access(0, 1'b0, 32'h20, 2'b10, 32'hFFFF_FFFF, d, e, lat);
      tests_run++;
      if (d !== 32'h1234_5678 || e !== 1'b0 || lat != 4) begin
         tests_failed++;
         $display("[TB] FAIL word_load: got data=%h err=%b lat=%0d, expected data=12345678 err=0 lat=4", d, e, lat);
      end
   endtask

   task automatic test_byte();
      logic [31:0] d;
      logic        e;
      int          lat;
      access(0, 1'b1, 32'h23, 2'b00, 32'h5555_55AB, d, e, lat);
      model_store(32'h23, 2'b00, 32'h5555_55AB);
      tests_run++;
      if (e !== 1'b0 || lat != 4) begin
         tests_failed++;
         $display("[TB] FAIL byte_store: got err=%b lat=%0d, expected err=0 lat=4", e, lat);
      end
      access(0, 1'b0, 32'h23, 2'b00, 32'h0, d, e, lat);
      tests_run++;
      if (d !== 32'h0000_00AB || e !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL byte_load: got data=%h err=%b, expected data=000000ab err=0", d, e);
      end
      access(0, 1'b0, 32'h20, 2'b10, 32'h0, d, e, lat);
      tests_run++;
      if (d !== 32'hAB34_5678 || e !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL byte_word_view: got data=%h err=%b, expected data=ab345678 err=0", d, e);
      end
   endtask

   task automatic test_half();
      logic [31:0] d;
      logic        e;
      int          lat;
      access(0, 1'b1, 32'h22, 2'b01, 32'h1234_CAFE, d, e, lat);
      model_store(32'h22, 2'b01, 32'h1234_CAFE);
      tests_run++;
      if (e !== 1'b0 || lat != 4) begin
         tests_failed++;
         $display("[TB] FAIL half_store: got err=%b lat=%0d, expected err=0 lat=4", e, lat);
      end
      access(0, 1'b0, 32'h22, 2'b01, 32'h0, d, e, lat);
      tests_run++;
      if (d !== 32'h0000_CAFE || e !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL half_load: got data=%h err=%b, expected data=0000cafe err=0", d, e);
      end
      access(0, 1'b0, 32'h20, 2'b10, 32'h0, d, e, lat);
      tests_run++;
      if (d !== 32'hCAFE_5678 || e !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL half_word_view: got data=%h err=%b, expected data=cafe5678 err=0", d, e);
      end
   endtask

   task automatic test_faults();
      logic [31:0] d;
      logic        e;
      int          lat;
      bit          fw  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] fa  [5] = '{32'h21, 32'h22, 32'h20, 32'h20, 32'h1000};
      logic [1:0]  fs  [5] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
      for (int k = 0; k < 5; k++) begin
         access(0, fw[k], fa[k], fs[k], 32'hFFFF_FFFF, d, e, lat);
         tests_run++;
         if (e !== 1'b1 || d !== 32'h0 || lat != 4) begin
            tests_failed++;
            $display("[TB] FAIL fault_%0d: got err=%b data=%h lat=%0d, expected err=1 data=0 lat=4", k, e, d, lat);
         end
      end
      access(0, 1'b0, 32'h20, 2'b10, 32'h0, d, e, lat);
      tests_run++;
      if (d !== 32'hCAFE_5678 || e !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL fault_ram_unchanged: got data=%h err=%b, expected data=cafe5678 err=0", d, e);
      end
   endtask

   task automatic test_random();
      logic [31:0] d, a, wd, exp_d;
      logic        e, exp_e;
      logic [1:0]  s;
      bit          w;
      int          lat;
      for (int k = 0; k < 16; k++) begin
         wd = $urandom;
         a  = 32'h40 + 32'(4 * k);
         access(0, 1'b1, a, 2'b10, wd, d, e, lat);
         model_store(a, 2'b10, wd);
         tests_run++;
         if (e !== 1'b0 || lat != 4) begin
            tests_failed++;
            $display("[TB] FAIL rand_fill_%0d: got err=%b lat=%0d, expected err=0 lat=4", k, e, lat);
         end
      end
      for (int k = 0; k < 80; k++) begin
         w  = 1'($urandom_range(0, 1));
         s  = 2'($urandom_range(0, 3));
         wd = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0:       a = 32'h0000_1000;
               1:       a = 32'h0000_1000 + 32'($urandom_range(0, 255));
               2:       a = 32'hFFFF_FFFC;
               default: a = 32'h8000_0000;
            endcase
         end else begin
            a = 32'h40 + 32'($urandom_range(0, 63));
         end
         exp_e = model_fault(a, s, 64'd0, 64'd4096);
         exp_d = (w || exp_e) ? 32'h0 : model_load(a, s);
         access(0, w, a, s, wd, d, e, lat);
         if (w && !exp_e) model_store(a, s, wd);
         tests_run++;
         if (d !== exp_d || e !== exp_e || lat != 4) begin
            tests_failed++;
            $display("[TB] FAIL rand_%0d (we=%b addr=%h size=%0d): got data=%h err=%b lat=%0d, expected data=%h err=%b lat=4",
                     k, w, a, s, d, e, lat, exp_d, exp_e);
         end
      end
   endtask

   task automatic test_latency0();
      logic [31:0] d;
      logic        e;
      int          lat;
      bit          exp_ready, exp_busy;
      access(1, 1'b1, 32'h1004, 2'b10, 32'hA5A5_0F0F, d, e, lat);
      tests_run++;
      if (e !== 1'b0 || lat != 2) begin
         tests_failed++;
         $display("[TB] FAIL lat0_store: got err=%b lat=%0d, expected err=0 lat=2", e, lat);
      end
      access(1, 1'b1, 32'h10FC, 2'b10, 32'h0BAD_F00D, d, e, lat);
      access(1, 1'b0, 32'h10FC, 2'b10, 32'h0, d, e, lat);
      tests_run++;
      if (d !== 32'h0BAD_F00D || e !== 1'b0 || lat != 2) begin
         tests_failed++;
         $display("[TB] FAIL lat0_top_word: got data=%h err=%b lat=%0d, expected data=0badf00d err=0 lat=2", d, e, lat);
      end
      access(1, 1'b0, 32'h0FFC, 2'b10, 32'h0, d, e, lat);
      tests_run++;
      if (e !== model_fault(32'h0FFC, 2'b10, 64'h1000, 64'd256) || d !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL lat0_below_base: got err=%b data=%h, expected err=1 data=0", e, d);
      end
      access(1, 1'b0, 32'h1100, 2'b10, 32'h0, d, e, lat);
      tests_run++;
      if (e !== 1'b1 || d !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL lat0_past_end: got err=%b data=%h, expected err=1 data=0", e, d);
      end
      // Request held high: responses every third cycle, busy in the two cycles between
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h1004; size0 = 2'b10; wdata0 = 32'h0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         exp_ready = (k % 3 == 0);
         exp_busy  = (k % 3 != 0);
         tests_run++;
         if ({ready0, busy0} !== {exp_ready, exp_busy}) begin
            tests_failed++;
            $display("[TB] FAIL lat0_held_cycle_%0d: got ready=%b busy=%b, expected ready=%b busy=%b",
                     k, ready0, busy0, exp_ready, exp_busy);
         end
         if (exp_ready) begin
            tests_run++;
            if (rdata0 !== 32'hA5A5_0F0F || err0 !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL lat0_held_data_%0d: got data=%h err=%b, expected data=a5a50f0f err=0",
                        k, rdata0, err0);
            end
         end
      end
      req0 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req = 1'b0; we = 1'b0; addr = 32'h0; size = 2'b00; wdata = 32'h0;
      req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; size0 = 2'b00; wdata0 = 32'h0;
      test_reset();
      test_reset_abort();
      test_word();
      test_byte();
      test_half();
      test_faults();
      test_random();
      test_latency0();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
